// File: rtl/mpy_sequencer_pkg.sv
// rtl/mpy_sequencer_pkg.sv - shared widths and state encoding for the MPY/MPYS sequencer
package mpy_sequencer_pkg;

    localparam int OPW        = 16;
    localparam int MULW       = 18;
    localparam int PRODW      = 2 * OPW;
    localparam int SETTLE_MIN = 18;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

endpackage

// File: rtl/mpy_sign_fix.sv
// rtl/mpy_sign_fix.sv - conditional two's-complement used for operand abs and product sign restore
import mpy_sequencer_pkg::*;

module mpy_sign_fix #(
    parameter int W = OPW
) (
    input  logic [W-1:0] din,
    input  logic         negate,
    output logic [W-1:0] dout
);

    // Negate with natural W-bit wrap; abs(most-negative) stays as its unsigned magnitude
    always_comb begin
        dout = negate ? (~din + W'(1)) : din;
    end

endmodule

// File: rtl/mpy_sequencer.sv
// rtl/mpy_sequencer.sv - start/done wrapper that drives the shared shift-add multiplier
import mpy_sequencer_pkg::*;

module mpy_sequencer #(
    parameter int SETTLE = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_signed,
    input  logic [OPW-1:0]    op_a,
    input  logic [OPW-1:0]    op_b,
    output logic              busy,
    output logic              done,
    output logic [OPW-1:0]    prod_hi,
    output logic [OPW-1:0]    prod_lo,
    output logic [MULW-1:0]   mul_a,
    output logic [MULW-1:0]   mul_b,
    input  logic [2*MULW-1:0] mul_p
);

    // The multiplier has no handshake, so the wait is the only thing guaranteeing a settled product
    if (SETTLE < SETTLE_MIN) begin : g_settle_check
        $error("mpy_sequencer: SETTLE must be at least SETTLE_MIN");
    end

    // SETTLE-1 always fits in clog2(SETTLE) bits
    localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t            state_q;
    state_t            state_d;
    logic              signed_q;
    logic              neg_q;
    logic [OPW-1:0]    op_a_q;
    logic [OPW-1:0]    op_b_q;
    logic [CNTW-1:0]   cnt_q;
    logic [OPW-1:0]    mag_a;
    logic [OPW-1:0]    mag_b;
    logic [PRODW-1:0]  result;
    logic              unused_mul_p_hi;

    // Upper product bits are always zero for 16-bit magnitudes
    assign unused_mul_p_hi = ^mul_p[2*MULW-1:PRODW];

    mpy_sign_fix #(.W(OPW)) u_fix_a (
        .din    (op_a_q),
        .negate (signed_q & op_a_q[OPW-1]),
        .dout   (mag_a)
    );

    mpy_sign_fix #(.W(OPW)) u_fix_b (
        .din    (op_b_q),
        .negate (signed_q & op_b_q[OPW-1]),
        .dout   (mag_b)
    );

    mpy_sign_fix #(.W(PRODW)) u_fix_p (
        .din    (mul_p[PRODW-1:0]),
        .negate (neg_q),
        .dout   (result)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; done marks the cycle the result first shows on prod_*
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy    = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, multiplier drive, settle counter and product capture
    always_ff @(posedge clk) begin
        if (reset) begin
            signed_q <= 1'b0;
            neg_q    <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            cnt_q    <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            prod_hi  <= '0;
            prod_lo  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        signed_q <= is_signed;
                        op_a_q   <= op_a;
                        op_b_q   <= op_b;
                    end
                end
                ST_LOAD: begin
                    mul_a <= {{(MULW-OPW){1'b0}}, mag_a};
                    mul_b <= {{(MULW-OPW){1'b0}}, mag_b};
                    neg_q <= signed_q & (op_a_q[OPW-1] ^ op_b_q[OPW-1]);
                    cnt_q <= CNTW'(SETTLE - 1);
                end
                ST_WAIT: begin
                    // Product is registered on the last wait edge so it is already valid alongside done
                    if (cnt_q == '0) begin
                        prod_hi <= result[PRODW-1:OPW];
                        prod_lo <= result[OPW-1:0];
                    end else begin
                        cnt_q <= cnt_q - CNTW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mpy_sequencer.md
Name: mpy_sequencer

Overview:
Control stage that sits directly upstream and downstream of the shared 18x18 shift-add multiplier, and serves the CPU MPY/MPYS microcode.
- Accepts a 16-bit operand pair and a signed/unsigned mode from the CPU core on a start/done handshake.
- Drives the multiplier's held a/b inputs and waits a fixed settle count, because the multiplier has no handshake.
- Captures the 36-bit product, applies sign correction, and returns the result as two 16-bit register words.

Parameters:
SETTLE, 20, cycles to wait after driving operands before sampling mul_p; must be >= 18, with a compile-time check.
- The multiplier needs 1 edge to detect the operand change and 17 edges to accumulate.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; accepted only in IDLE
is_signed  in  1  1 = MPYS (two's complement), 0 = MPY (unsigned); sampled with start
op_a  in  16  multiplicand; sampled with start
op_b  in  16  multiplier; sampled with start
busy  out  1  high from the cycle after acceptance until done
done  out  1  one-cycle pulse; result valid from this cycle on
prod_hi  out  16  result bits 31:16
prod_lo  out  16  result bits 15:0
mul_a  out  18  to multiplier a; registered
mul_b  out  18  to multiplier b; registered
mul_p  in  36  from multiplier p

Behaviour:
Reset:
- State goes to IDLE.
- busy, done, prod_hi, prod_lo, mul_a and mul_b all go to 0.
- Reset asserted mid-operation abandons the operation; no done is issued.

State machine (one-hot or binary, implementer's choice): IDLE -> LOAD -> WAIT -> CAPTURE -> IDLE.
- IDLE: if start is high, register is_signed, op_a and op_b, then go to LOAD.
- LOAD:
  - Drive mul_a and mul_b with magnitudes zero-extended to 18 bits.
    - Unsigned mode: the operand itself.
    - Signed mode: abs(operand). abs(0x8000) = 0x08000, which fits.
  - Register neg = is_signed & (a[15] ^ b[15]).
  - Load the counter with SETTLE-1 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle; at 0 go to CAPTURE.
  - mul_a and mul_b stay stable throughout.
- CAPTURE:
  - m = mul_p[31:0]; bits 35:32 are always 0 for 16-bit magnitudes and are ignored.
  - r = neg ? (~m + 1) : m, with 32-bit wrap.
  - prod_hi = r[31:16], prod_lo = r[15:0].
  - done = 1 for this cycle only; go to IDLE.

Handshake and timing:
- start accepted at edge N gives done high in cycle N+SETTLE+2.
- busy is high in cycles N+1 through N+SETTLE+1 and low in the done cycle.
- start while busy or in the done cycle is ignored; it is not queued.
- start is accepted again in the first IDLE cycle after done.

Output holding:
- prod_hi and prod_lo hold their value until the next CAPTURE or reset.
- mul_a and mul_b keep their last values in IDLE so the multiplier stays quiescent.

Operand corner cases:
- Back-to-back identical operands: the multiplier does not restart. Its product is already final, and the fixed wait still applies, so results are correct.
- A zero operand needs no special case.
- Signed -32768 * -32768 = 0x40000000 (no overflow in 32 bits).

Decomposition:
Shared package holds:
- state encoding constants: ST_IDLE, ST_LOAD, ST_WAIT, ST_CAPTURE;
- OPW = 16, MULW = 18;
- SETTLE_MIN = 18.

One natural sub-module: mpy_sign_fix.
- Combinational abs-on-input and conditional two's-complement-on-output helper.
- Instantiated once for the input pair and once for the output.
- The multiplier itself is instantiated by the parent alongside this block, not inside it.

Test Plan:
1. Reset then idle: all outputs 0. Hold reset high through a start; no busy and no done.
2. Unsigned basic: op_a=0x1234, op_b=0x5678, is_signed=0, with the real multiplier attached. Required response:
   - done in cycle N+22 (SETTLE=20);
   - prod_hi=0x0626, prod_lo=0x0060;
   - busy high for exactly 21 cycles.
3. Unsigned max: 0xFFFF*0xFFFF -> 0xFFFE/0x0001. Then repeat the same operands back-to-back -> same result and same latency.
4. Signed: 0xFFFF*0x0002 -> 0xFFFF/0xFFFE. 0x8000*0x8000 -> 0x4000/0x0000. 0x8000*0x0001 -> 0xFFFF/0x8000. Unsigned 0x8000*0x8000 -> 0x4000/0x0000. 0xFFFF*0x0000 (signed) -> 0x0000/0x0000.
5. Handshake abuse: start pulsed every cycle during busy -> exactly one done; the second request is accepted only in the IDLE cycle after done.
6. Reset mid-WAIT at cycle N+10: busy drops the next cycle, no done pulse, prod_hi/prod_lo=0, mul_a/mul_b=0. A new start afterwards completes normally.
